dm_arbiter: RTL and testbench

- Arbitrates two requesters onto the single-port synchronous data RAM behind the data-memory wrapper: 64 x 32-bit words, 6-bit word address, write enable, 1-cycle registered read.
- Port 0 is the CPU load/store path. Port 1 is the debug/loader port.
- Sequences each access through a small FSM with round-robin fairness.
- Checks address alignment and range before touching the RAM.

---
 rtl/dm_arbiter.sv | 150 +++++++++++++++
 tb/tb_dm_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data RAM. Port 0 is the CPU
// load/store path and port 1 the debug/loader port. Every output is registered.
module dm_arbiter #(
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = 6
) (
    input  logic              clk_dm,
    input  logic              rst_n,
    // Handshake: pN_req stays high with stable fields until pN_ack pulses.
    // pN_done pulses once per accepted access, and pN_rdata/pN_err are
    // valid only while pN_done is high.
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_ack,
    output logic              p0_done,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_ack,
    output logic              p1_done,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] LAST_WAIT = 2'(READ_LAT - 1);

    state_t      state, next_state;
    logic        last_grant;
    logic        gnt_valid, gnt_port;
    logic        sel_we, sel_err;
    logic [31:0] sel_addr, sel_wdata;
    logic        lat_port, lat_we, lat_err;
    logic [1:0]  wait_cnt;

    // On a tie the port that did not win the last tie is granted.
    always_comb begin
        gnt_valid = p0_req | p1_req;
        gnt_port  = 1'b0;
        if (p0_req && p1_req) begin
            gnt_port = ~last_grant;
        end else if (p1_req) begin
            gnt_port = 1'b1;
        end
        sel_we    = gnt_port ? p1_we    : p0_we;
        sel_addr  = gnt_port ? p1_addr  : p0_addr;
        sel_wdata = gnt_port ? p1_wdata : p0_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (gnt_valid) next_state = ISSUE;
            ISSUE:   next_state = (lat_we || lat_err) ? DONE : WAIT;
            WAIT:    if (wait_cnt == LAST_WAIT) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pulses default low each cycle; they are raised on the edge entering
    // the state that owns them.
    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            wait_cnt   <= 2'd0;
            busy       <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_done    <= 1'b0;
            p1_done    <= 1'b0;
            p0_rdata   <= 32'h0;
            p1_rdata   <= 32'h0;
            p0_err     <= 1'b0;
            p1_err     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= 32'h0;
            ram_we     <= 1'b0;
        end else begin
            busy     <= (next_state != IDLE);
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_done  <= 1'b0;
            p1_done  <= 1'b0;
            p0_rdata <= 32'h0;
            p1_rdata <= 32'h0;
            p0_err   <= 1'b0;
            p1_err   <= 1'b0;
            ram_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        lat_port <= gnt_port;
                        lat_we   <= sel_we;
                        lat_err  <= sel_err;
                        if (p0_req && p1_req) last_grant <= gnt_port;
                        p0_ack   <= ~gnt_port;
                        p1_ack   <= gnt_port;
                        ram_addr <= sel_addr[ADDR_W+1:2];
                        ram_din  <= sel_wdata;
                        ram_we   <= sel_we & ~sel_err;
                        wait_cnt <= 2'd0;
                    end
                end
                ISSUE: begin
                    if (next_state == DONE) begin
                        p0_done <= ~lat_port;
                        p1_done <= lat_port;
                        p0_err  <= ~lat_port & lat_err;
                        p1_err  <= lat_port & lat_err;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (next_state == DONE) begin
                        p0_done  <= ~lat_port;
                        p1_done  <= lat_port;
                        p0_rdata <= lat_port ? 32'h0 : ram_dout;
                        p1_rdata <= lat_port ? ram_dout : 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: two instances (READ_LAT 1 and 3), each with a
// behavioural RAM, checked against a shadow memory and expected-result queues.
module tb_dm_arbiter;

    localparam int NI = 2;

    logic        clk_dm = 1'b0;
    logic        rst_n;
    logic        p0_req [NI], p0_we [NI], p1_req [NI], p1_we [NI];
    logic [31:0] p0_addr [NI], p0_wdata [NI], p1_addr [NI], p1_wdata [NI];
    logic        p0_ack [NI], p0_done [NI], p0_err [NI];
    logic        p1_ack [NI], p1_done [NI], p1_err [NI];
    logic [31:0] p0_rdata [NI], p1_rdata [NI];
    logic [5:0]  ram_addr [NI];
    logic [31:0] ram_din [NI], ram_dout [NI];
    logic        ram_we [NI], busy [NI];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ack_cyc [NI][2];
    int          p0_done_cnt = 0;
    logic        prev_we [NI];
    logic [31:0] sh_mem [NI][64];
    logic [35:0] exp_q0 [$];
    logic [35:0] exp_q1 [$];
    logic [37:0] wr_q [$];
    logic        ack_log [$];

    always #5 clk_dm = ~clk_dm;
    always @(posedge clk_dm) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem  [64];
        logic [31:0] pipe [LAT];

        dm_arbiter #(.READ_LAT(LAT), .ADDR_W(6)) u_dut (
            .clk_dm  (clk_dm),
            .rst_n   (rst_n),
            .p0_req  (p0_req[g]),
            .p0_we   (p0_we[g]),
            .p0_addr (p0_addr[g]),
            .p0_wdata(p0_wdata[g]),
            .p0_ack  (p0_ack[g]),
            .p0_done (p0_done[g]),
            .p0_rdata(p0_rdata[g]),
            .p0_err  (p0_err[g]),
            .p1_req  (p1_req[g]),
            .p1_we   (p1_we[g]),
            .p1_addr (p1_addr[g]),
            .p1_wdata(p1_wdata[g]),
            .p1_ack  (p1_ack[g]),
            .p1_done (p1_done[g]),
            .p1_rdata(p1_rdata[g]),
            .p1_err  (p1_err[g]),
            .ram_addr(ram_addr[g]),
            .ram_din (ram_din[g]),
            .ram_we  (ram_we[g]),
            .ram_dout(ram_dout[g]),
            .busy    (busy[g])
        );

        initial for (int k = 0; k < 64; k++) mem[k] = 32'h0;

        always @(posedge clk_dm) begin
            if (ram_we[g]) mem[ram_addr[g]] <= ram_din[g];
            pipe[0] <= mem[ram_addr[g]];
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign ram_dout[g] = pipe[LAT-1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check_done(input int i, input int port);
        logic [35:0] e;
        logic [31:0] rd;
        logic        er, other;
        if (port == 0) begin
            rd    = p0_rdata[i];
            er    = p0_err[i];
            other = p1_done[i] | p1_ack[i] | p1_err[i] | (p1_rdata[i] != 32'h0);
            if (exp_q0.size() == 0) begin
                check("p0_unexpected_done", 1, 0);
                return;
            end
            e = exp_q0.pop_front();
        end else begin
            rd    = p1_rdata[i];
            er    = p1_err[i];
            other = p0_done[i] | p0_ack[i] | p0_err[i] | (p0_rdata[i] != 32'h0);
            if (exp_q1.size() == 0) begin
                check("p1_unexpected_done", 1, 0);
                return;
            end
            e = exp_q1.pop_front();
        end
        check(port == 0 ? "p0_rdata" : "p1_rdata", rd, e[31:0]);
        check(port == 0 ? "p0_err" : "p1_err", er, e[32]);
        check(port == 0 ? "p0_ack_to_done" : "p1_ack_to_done", cyc - ack_cyc[i][port], e[35:33]);
        check("other_port_quiet", other, 0);
    endtask

    always @(negedge clk_dm) begin
        for (int i = 0; i < NI; i++) begin
            if (p0_ack[i]) begin
                ack_cyc[i][0] = cyc;
                ack_log.push_back(1'b0);
            end
            if (p1_ack[i]) begin
                ack_cyc[i][1] = cyc;
                ack_log.push_back(1'b1);
            end
            if (p0_ack[i] && p1_ack[i]) check("dual_ack", 1, 0);
            if (p0_done[i]) begin
                if (i == 0) p0_done_cnt++;
                check_done(i, 0);
            end
            if (p1_done[i]) check_done(i, 1);
            if (!p0_done[i] && (p0_err[i] || p0_rdata[i] != 32'h0))
                check("p0_outputs_idle", {p0_err[i], p0_rdata[i]}, 0);
            if (!p1_done[i] && (p1_err[i] || p1_rdata[i] != 32'h0))
                check("p1_outputs_idle", {p1_err[i], p1_rdata[i]}, 0);
            if (ram_we[i]) begin
                if (prev_we[i]) check("ram_we_single_cycle", 1, 0);
                if (wr_q.size() == 0) check("unexpected_ram_write", 1, 0);
                else check("ram_write", {ram_addr[i], ram_din[i]}, wr_q.pop_front());
            end
            prev_we[i] = ram_we[i];
        end
    end

    task automatic do_req(input int i, input int port, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata, input int exp_wait);
        logic        err, got;
        logic [35:0] e;
        int          waited;
        err      = (addr[1:0] != 2'b00) || (addr[31:8] != 24'h0);
        e[31:0]  = (err || we) ? 32'h0 : sh_mem[i][addr[7:2]];
        e[32]    = err;
        e[35:33] = (err || we) ? 3'd1 : 3'(1 + lat_of(i));
        if (we && !err) begin
            sh_mem[i][addr[7:2]] = wdata;
            wr_q.push_back({addr[7:2], wdata});
        end
        if (port == 0) begin
            exp_q0.push_back(e);
            p0_we[i] = we; p0_addr[i] = addr; p0_wdata[i] = wdata; p0_req[i] = 1'b1;
        end else begin
            exp_q1.push_back(e);
            p1_we[i] = we; p1_addr[i] = addr; p1_wdata[i] = wdata; p1_req[i] = 1'b1;
        end
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 40) begin
            @(negedge clk_dm);
            waited++;
            got = (port == 0) ? p0_ack[i] : p1_ack[i];
        end
        if (port == 0) p0_req[i] = 1'b0;
        else p1_req[i] = 1'b0;
        if (!got) check("ack_timeout", 0, 1);
        else if (exp_wait > 0) check("req_to_ack", waited, exp_wait);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || wr_q.size() != 0) && n < 60) begin
            @(negedge clk_dm);
            n++;
        end
        if (n >= 60) check("drain_timeout", 1, 0);
        @(negedge clk_dm);
    endtask

    initial begin
        int done_before;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            p0_req[i] = 1'b0; p0_we[i] = 1'b0; p0_addr[i] = 32'h0; p0_wdata[i] = 32'h0;
            p1_req[i] = 1'b0; p1_we[i] = 1'b0; p1_addr[i] = 32'h0; p1_wdata[i] = 32'h0;
            prev_we[i] = 1'b0;
            for (int k = 0; k < 64; k++) sh_mem[i][k] = 32'h0;
        end
        repeat (3) @(negedge clk_dm);
        for (int i = 0; i < NI; i++) begin
            check("rst_busy", busy[i], 0);
            check("rst_handshake", {p0_ack[i], p0_done[i], p0_err[i], p1_ack[i], p1_done[i], p1_err[i], ram_we[i]}, 0);
            check("rst_rdata", {p0_rdata[i], p1_rdata[i]}, 0);
            check("rst_ram_bus", {ram_addr[i], ram_din[i]}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk_dm);

        // Single write then read back on port 0.
        do_req(0, 0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1);
        drain();
        do_req(0, 0, 1'b0, 32'h0000_0010, 32'h0, 1);
        drain();

        // Both ports requesting back to back must alternate, port 0 first.
        ack_log.delete();
        fork
            for (int k = 0; k < 3; k++) do_req(0, 0, 1'b0, 32'h0000_0010, 32'h0, 0);
            for (int k = 0; k < 3; k++) do_req(0, 1, 1'b0, 32'h0000_0020, 32'h0, 0);
        join
        drain();
        check("rr_grant_count", ack_log.size(), 6);
        for (int k = 0; k < ack_log.size() && k < 6; k++) check("rr_grant_order", ack_log[k], k % 2);

        // Misaligned and out-of-range writes must not touch word 0.
        do_req(0, 1, 1'b1, 32'h0000_0000, 32'hA5A5_0001, 1);
        drain();
        do_req(0, 1, 1'b1, 32'h0000_0102, 32'h1111_1111, 1);
        drain();
        do_req(0, 1, 1'b1, 32'h0000_0100, 32'h2222_2222, 1);
        drain();
        do_req(0, 1, 1'b0, 32'h8000_0000, 32'h0, 1);
        drain();
        do_req(0, 1, 1'b0, 32'h0000_0000, 32'h0, 1);
        drain();

        for (int k = 0; k < 10; k++) begin
            do_req(0, $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                   {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 1);
            drain();
        end

        // Reset asserted during the WAIT cycle of a read.
        done_before = p0_done_cnt;
        do_req(0, 0, 1'b0, 32'h0000_0010, 32'h0, 1);
        @(negedge clk_dm);
        check("wait_busy", busy[0], 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", {busy[0], p0_ack[0], p0_done[0], p0_err[0], ram_we[0]}, 0);
        check("mid_rst_data", {p0_rdata[0], ram_addr[0], ram_din[0]}, 0);
        exp_q0.delete();
        repeat (3) @(negedge clk_dm);
        check("no_done_after_rst", p0_done_cnt, done_before);
        rst_n = 1'b1;
        @(negedge clk_dm);
        do_req(0, 0, 1'b0, 32'h0000_0010, 32'h0, 1);
        drain();

        // READ_LAT = 3 instance: read of word 63 returns the last write.
        do_req(1, 0, 1'b1, 32'h0000_00FC, 32'h1234_5678, 1);
        drain();
        do_req(1, 0, 1'b1, 32'h0000_00FC, 32'hC0FF_EE63, 1);
        drain();
        do_req(1, 1, 1'b0, 32'h0000_00FC, 32'h0, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
